// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage register: state encoding,
// default widths and control-bit positions.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_CTRL_W = 4;
    localparam int DEF_CNT_W  = 16;

    localparam int CTRL_RF_WE  = 0;
    localparam int CTRL_MEM_WE = 1;
    localparam int CTRL_BRANCH = 2;

endpackage

// File: rtl/pipe_entry.sv
// One stage entry: payload register that only changes on load, plus a
// control register that can additionally be cleared without a load.
module pipe_entry #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load,
    input  logic              i_clr_ctrl,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_ctrl <= '0;
        end else begin
            if (i_load)
                r_data <= i_data;
            // Clear wins so a killed beat can never leave a write enable behind
            if (i_clr_ctrl)
                r_ctrl <= '0;
            else if (i_load)
                r_ctrl <= i_ctrl;
        end
    end

    assign o_data = r_data;
    assign o_ctrl = r_ctrl;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with optional skid entry, flush, control gating
// and a saturating stall counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int SKID   = 1,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    input  logic              flush_i,
    output logic [1:0]        level_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    pipe_state_e       r_state, w_nxt;
    logic              w_in_fire, w_out_fire, w_stall;
    logic              w_main_load, w_skid_load, w_main_from_skid;
    logic [DATA_W-1:0] w_main_din, w_main_data, w_skid_data;
    logic [CTRL_W-1:0] w_main_cin, w_main_ctrl, w_skid_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign out_valid_o = (r_state != ST_EMPTY);
    assign w_in_fire   = in_valid_i & in_ready_o;
    assign w_out_fire  = out_valid_o & out_ready_i;
    assign w_stall     = out_valid_o & ~out_ready_i;

    always_comb begin
        w_nxt            = r_state;
        w_main_load      = 1'b0;
        w_skid_load      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush_i) begin
            w_nxt = ST_EMPTY;
        end else begin
            unique case (r_state)
                ST_EMPTY: if (w_in_fire) begin
                    w_nxt       = ST_FULL;
                    w_main_load = 1'b1;
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load = 1'b1;
                    end else if (w_out_fire) begin
                        w_nxt = ST_EMPTY;
                    end else if (w_in_fire && SKID != 0) begin
                        w_nxt       = ST_SKID;
                        w_skid_load = 1'b1;
                    end
                end
                ST_SKID: if (w_out_fire) begin
                    w_nxt            = ST_FULL;
                    w_main_load      = 1'b1;
                    w_main_from_skid = 1'b1;
                end
                default: w_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= ST_EMPTY;
        else       r_state <= w_nxt;
    end

    // The skid entry is always older than the input, so it refills main first
    assign w_main_din = w_main_from_skid ? w_skid_data : in_data_i;
    assign w_main_cin = w_main_from_skid ? w_skid_ctrl : in_ctrl_i;

    pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_main_load),
        .i_clr_ctrl (flush_i),
        .i_data     (w_main_din),
        .i_ctrl     (w_main_cin),
        .o_data     (w_main_data),
        .o_ctrl     (w_main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            logic r_in_ready;

            pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
                .clk_i      (clk_i),
                .rst_i      (rst_i),
                .i_load     (w_skid_load),
                .i_clr_ctrl (flush_i),
                .i_data     (in_data_i),
                .i_ctrl     (in_ctrl_i),
                .o_data     (w_skid_data),
                .o_ctrl     (w_skid_ctrl)
            );

            // Registered ready breaks the combinational path from out_ready_i
            always_ff @(posedge clk_i) begin
                if (rst_i) r_in_ready <= 1'b1;
                else       r_in_ready <= (w_nxt != ST_SKID);
            end
            assign in_ready_o = r_in_ready;
        end else begin : g_noskid
            assign w_skid_data = '0;
            assign w_skid_ctrl = '0;
            assign in_ready_o  = ~out_valid_o | out_ready_i;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (w_stall && r_stall_cnt != {CNT_W{1'b1}})
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign out_data_o  = w_main_data;
    assign out_ctrl_o  = w_main_ctrl & {CTRL_W{out_valid_o}};
    assign level_o     = r_state;
    assign stall_cnt_o = r_stall_cnt;

endmodule
